// File: rtl/calendar_pkg.sv
// calendar_pkg
// Shared definitions for the date counter: field widths and bit positions of
// the packed date {year[22:9], month[8:5], day[4:0]}, month constants, the
// load-sequence FSM state enum, and small packing / leap helpers.
package calendar_pkg;

    localparam int DATE_W    = 23;
    localparam int YEAR_W    = 14;
    localparam int MONTH_W   = 4;
    localparam int DAY_W     = 5;
    localparam int RES_W     = 9;   // year % 400 fits in 9 bits
    localparam int YEAR_LSB  = 9;
    localparam int MONTH_LSB = 5;
    localparam int DAY_LSB   = 0;

    localparam logic [MONTH_W-1:0] M_JAN = 4'd1;
    localparam logic [MONTH_W-1:0] M_FEB = 4'd2;
    localparam logic [MONTH_W-1:0] M_APR = 4'd4;
    localparam logic [MONTH_W-1:0] M_JUN = 4'd6;
    localparam logic [MONTH_W-1:0] M_SEP = 4'd9;
    localparam logic [MONTH_W-1:0] M_NOV = 4'd11;
    localparam logic [MONTH_W-1:0] M_DEC = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESID,
        S_CHECK
    } state_e;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
    } date_t;

    function automatic date_t pack_date(logic [YEAR_W-1:0] y, logic [MONTH_W-1:0] m,
                                        logic [DAY_W-1:0] d);
        date_t r;
        r.year  = y;
        r.month = m;
        r.day   = d;
        return r;
    endfunction

    function automatic date_t unpack_date(logic [DATE_W-1:0] v);
        return pack_date(v[YEAR_LSB +: YEAR_W], v[MONTH_LSB +: MONTH_W], v[DAY_LSB +: DAY_W]);
    endfunction

    // Leap from the year's two LSBs and its mod-400 residue: divisible by 4,
    // and not a century unless the century is a multiple of 400.
    function automatic logic is_leap(logic [1:0] year_lo, logic [RES_W-1:0] r400);
        return (year_lo == 2'b00) && (r400 != 9'd100) && (r400 != 9'd200) && (r400 != 9'd300);
    endfunction

endpackage

// File: rtl/date_counter_month_len.sv
// month_len
// Combinational days-in-month lookup.
//   month : 4-bit month number (values outside 1..12 report 31)
//   leap  : current year is a leap year
//   dim   : number of days in the month
module month_len
    import calendar_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dim
);

    always_comb begin
        dim = 5'd31;
        if (month == M_FEB)
            dim = leap ? 5'd29 : 5'd28;
        else if (month == M_APR || month == M_JUN || month == M_SEP || month == M_NOV)
            dim = 5'd30;
    end

endmodule

// File: rtl/date_counter.sv
// date_counter
// Calendar register advancing one day per day_tick with Gregorian month length
// and leap handling. Leap status comes from a year-mod-400 residue kept in
// step with the year, so loads compute the residue by repeated subtraction
// (RESID state) instead of a divider.
// Optional feature macro: DATE_CNT_DEC_EN adds the day_dec port and decrement.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   day_tick   : advance one day (pulse)
//   day_dec    : retreat one day (pulse, DATE_CNT_DEC_EN only)
//   load       : request load of load_date (pulse, ignored while busy)
//   load_date  : {year, month, day} to load
//   now_date   : current packed date
//   leap       : current year is a leap year
//   busy       : load sequence in progress
//   load_err   : pulse, loaded date rejected
module date_counter
    import calendar_pkg::*;
#(
    parameter int RST_YEAR = 2000   // must be a multiple of 400 (residue resets to 0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
`ifdef DATE_CNT_DEC_EN
    input  logic              day_dec,
`endif
    input  logic              load,
    input  logic [DATE_W-1:0] load_date,
    output logic [DATE_W-1:0] now_date,
    output logic              leap,
    output logic              busy,
    output logic              load_err
);

    localparam date_t RST_DATE = pack_date(YEAR_W'(RST_YEAR), M_JAN, 5'd1);

    date_t              date_q, date_d, scr_q, scr_d, inc_date;
    logic [RES_W-1:0]   r400_q, r400_d, inc_r400;
    logic [YEAR_W-1:0]  sr_q, sr_d;
    state_e             state_q, state_d;
    logic               pend_inc_q, pend_inc_d;
    logic               load_err_q, load_err_d;
    logic               inc_req, dec_req;
    logic               scr_leap, scr_ok;
    logic [DAY_W-1:0]   dim_cur, dim_scr;

    assign leap     = is_leap(date_q.year[1:0], r400_q);
    assign scr_leap = is_leap(scr_q.year[1:0], sr_q[RES_W-1:0]);

    month_len u_len_cur (.month(date_q.month), .leap(leap),     .dim(dim_cur));
    month_len u_len_scr (.month(scr_q.month),  .leap(scr_leap), .dim(dim_scr));

    // Next-day value; the 16383 -> 0 wrap forces the residue to 0 because
    // 16383 % 400 = 383 would otherwise continue to 384.
    always_comb begin
        inc_date = date_q;
        inc_r400 = r400_q;
        if (date_q.day < dim_cur) begin
            inc_date.day = date_q.day + 5'd1;
        end else if (date_q.month < M_DEC) begin
            inc_date.month = date_q.month + 4'd1;
            inc_date.day   = 5'd1;
        end else begin
            inc_date.year  = date_q.year + 14'd1;
            inc_date.month = M_JAN;
            inc_date.day   = 5'd1;
            inc_r400 = (date_q.year == '1 || r400_q == 9'd399) ? '0 : r400_q + 9'd1;
        end
    end

`ifdef DATE_CNT_DEC_EN
    date_t              dec_date;
    logic [RES_W-1:0]   dec_r400;
    logic [MONTH_W-1:0] prev_month;
    logic [DAY_W-1:0]   dim_prev;
    logic               pend_dec_q, pend_dec_d;

    assign prev_month = date_q.month - 4'd1;
    month_len u_len_prev (.month(prev_month), .leap(leap), .dim(dim_prev));

    always_comb begin
        dec_date = date_q;
        dec_r400 = r400_q;
        if (date_q.day > 5'd1) begin
            dec_date.day = date_q.day - 5'd1;
        end else if (date_q.month > M_JAN) begin
            dec_date.month = prev_month;
            dec_date.day   = dim_prev;
        end else begin
            dec_date.year  = date_q.year - 14'd1;
            dec_date.month = M_DEC;
            dec_date.day   = 5'd31;
            if (date_q.year == '0)
                dec_r400 = 9'd383;
            else
                dec_r400 = (r400_q == '0) ? 9'd399 : r400_q - 9'd1;
        end
    end
`endif

    assign scr_ok = (scr_q.month >= M_JAN) && (scr_q.month <= M_DEC) &&
                    (scr_q.day >= 5'd1) && (scr_q.day <= dim_scr);

    always_comb begin
        date_d     = date_q;
        r400_d     = r400_q;
        scr_d      = scr_q;
        sr_d       = sr_q;
        state_d    = state_q;
        pend_inc_d = pend_inc_q;
        load_err_d = 1'b0;
        inc_req    = 1'b0;
        dec_req    = 1'b0;
`ifdef DATE_CNT_DEC_EN
        pend_dec_d = pend_dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Fresh pulses and ticks held over from a load merge here.
                inc_req    = day_tick | pend_inc_q;
                pend_inc_d = 1'b0;
`ifdef DATE_CNT_DEC_EN
                dec_req    = day_dec | pend_dec_q;
                pend_dec_d = 1'b0;
`endif
                if (inc_req && !dec_req) begin
                    date_d = inc_date;
                    r400_d = inc_r400;
                end
`ifdef DATE_CNT_DEC_EN
                else if (dec_req && !inc_req) begin
                    date_d = dec_date;
                    r400_d = dec_r400;
                end
`endif
                if (load) begin
                    scr_d   = unpack_date(load_date);
                    sr_d    = load_date[YEAR_LSB +: YEAR_W];
                    state_d = S_RESID;
                end
            end
            S_RESID, S_CHECK: begin
                pend_inc_d = pend_inc_q | day_tick;
`ifdef DATE_CNT_DEC_EN
                pend_dec_d = pend_dec_q | day_dec;
`endif
                if (state_q == S_RESID) begin
                    if (sr_q >= 14'd400)
                        sr_d = sr_q - 14'd400;
                    else
                        state_d = S_CHECK;
                end else begin
                    if (scr_ok) begin
                        date_d = scr_q;
                        r400_d = sr_q[RES_W-1:0];
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            date_q     <= RST_DATE;
            r400_q     <= '0;
            scr_q      <= '0;
            sr_q       <= '0;
            state_q    <= S_IDLE;
            pend_inc_q <= 1'b0;
            load_err_q <= 1'b0;
`ifdef DATE_CNT_DEC_EN
            pend_dec_q <= 1'b0;
`endif
        end else begin
            date_q     <= date_d;
            r400_q     <= r400_d;
            scr_q      <= scr_d;
            sr_q       <= sr_d;
            state_q    <= state_d;
            pend_inc_q <= pend_inc_d;
            load_err_q <= load_err_d;
`ifdef DATE_CNT_DEC_EN
            pend_dec_q <= pend_dec_d;
`endif
        end
    end

    assign now_date = date_q;
    assign busy     = (state_q != S_IDLE);
    assign load_err = load_err_q;

endmodule
